// File: rtl/writeback_queue_pkg.sv
// Shared CPU constants and the register write-request bundle used by
// the register file, pipeline and writeback queue.
package writeback_queue_pkg;

    localparam int WBQ_AW = 5;
    localparam int WBQ_DW = 32;

    typedef struct packed {
        logic [WBQ_AW-1:0] addr;
        logic [WBQ_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/writeback_queue_match.sv
// Youngest-match search over age-ordered candidates (index 0 oldest).
// Address 0 never hits.
module wbq_match
    import writeback_queue_pkg::*;
#(
    parameter int N  = 5,
    parameter int AW = WBQ_AW,
    parameter int DW = WBQ_DW
) (
    input  logic [N-1:0]         i_vld,
    input  logic [N-1:0][AW-1:0] i_addr,
    input  logic [N-1:0][DW-1:0] i_data,
    input  logic [AW-1:0]        i_ra,
    output logic                 o_hit,
    output logic [DW-1:0]        o_data
);

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        if (i_ra != '0) begin
            // later (younger) candidates overwrite earlier ones
            for (int k = 0; k < N; k++) begin
                if (i_vld[k] && (i_addr[k] == i_ra)) begin
                    o_hit  = 1'b1;
                    o_data = i_data[k];
                end
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Pending register-write FIFO merging ALU and load results onto the
// single register file write port, with bypass lookup for the read ports.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WBQ_AW,
    parameter int DW    = WBQ_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_alu_valid,
    input  logic [AW-1:0] i_alu_addr,
    input  logic [DW-1:0] i_alu_data,
    output logic          o_alu_ready,
    input  logic          i_mem_valid,
    input  logic [AW-1:0] i_mem_addr,
    input  logic [DW-1:0] i_mem_data,
    output logic          o_mem_ready,
    output logic          o_rf_we,
    output logic [AW-1:0] o_rf_waddr,
    output logic [DW-1:0] o_rf_wdata,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic          o_hit1,
    output logic          o_hit2,
    output logic [DW-1:0] o_byp1,
    output logic [DW-1:0] o_byp2,
    output logic          o_empty,
    output logic          o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int N  = DEPTH + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic [AW-1:0] ent_addr_q [DEPTH];
    logic [DW-1:0] ent_data_q [DEPTH];

    logic          mem_fire, alu_fire, push, pop;
    logic [AW-1:0] enq_addr;
    logic [DW-1:0] enq_data;

    logic [N-1:0]         cand_vld;
    logic [N-1:0][AW-1:0] cand_addr;
    logic [N-1:0][DW-1:0] cand_data;
    logic [PW-1:0]        idx;

    assign o_full      = (count_q == CW'(DEPTH));
    assign o_empty     = (count_q == '0);
    assign o_mem_ready = !o_full;
    assign o_alu_ready = !o_full && !i_mem_valid;

    assign mem_fire = i_mem_valid && o_mem_ready;
    assign alu_fire = i_alu_valid && o_alu_ready;
    assign enq_addr = mem_fire ? i_mem_addr : i_alu_addr;
    assign enq_data = mem_fire ? i_mem_data : i_alu_data;
    // writes to x0 finish the handshake but are dropped
    assign push     = (mem_fire || alu_fire) && (enq_addr != '0);
    assign pop      = !o_empty;

    always_comb begin
        head_d     = pop  ? head_q + 1'b1 : head_q;
        tail_d     = push ? tail_q + 1'b1 : tail_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        rf_we_d    = pop;
        rf_waddr_d = pop ? ent_addr_q[head_q] : rf_waddr_q;
        rf_wdata_d = pop ? ent_data_q[head_q] : rf_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            ent_addr_q[tail_q] <= enq_addr;
            ent_data_q[tail_q] <= enq_data;
        end
    end

    assign o_rf_we    = rf_we_q;
    assign o_rf_waddr = rf_waddr_q;
    assign o_rf_wdata = rf_wdata_q;

    // slot 0 is the write-port entry; slots 1.. follow FIFO age from head
    always_comb begin
        idx          = '0;
        cand_vld     = '0;
        cand_addr    = '0;
        cand_data    = '0;
        cand_vld[0]  = rf_we_q;
        cand_addr[0] = rf_waddr_q;
        cand_data[0] = rf_wdata_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx            = head_q + PW'(k);
            cand_vld[k+1]  = (CW'(k) < count_q);
            cand_addr[k+1] = ent_addr_q[idx];
            cand_data[k+1] = ent_data_q[idx];
        end
    end

    wbq_match #(.N(N), .AW(AW), .DW(DW)) u_match1 (
        .i_vld  (cand_vld),
        .i_addr (cand_addr),
        .i_data (cand_data),
        .i_ra   (i_ra1),
        .o_hit  (o_hit1),
        .o_data (o_byp1)
    );

    wbq_match #(.N(N), .AW(AW), .DW(DW)) u_match2 (
        .i_vld  (cand_vld),
        .i_addr (cand_addr),
        .i_data (cand_data),
        .i_ra   (i_ra2),
        .o_hit  (o_hit2),
        .o_data (o_byp2)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with a write-order scoreboard.
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW = WBQ_AW;
    localparam int DW = WBQ_DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_alu_valid = 1'b0;
    logic [AW-1:0] i_alu_addr = '0;
    logic [DW-1:0] i_alu_data = '0;
    logic          o_alu_ready;
    logic          i_mem_valid = 1'b0;
    logic [AW-1:0] i_mem_addr = '0;
    logic [DW-1:0] i_mem_data = '0;
    logic          o_mem_ready;
    logic          o_rf_we;
    logic [AW-1:0] o_rf_waddr;
    logic [DW-1:0] o_rf_wdata;
    logic [AW-1:0] i_ra1 = '0;
    logic [AW-1:0] i_ra2 = '0;
    logic          o_hit1, o_hit2;
    logic [DW-1:0] o_byp1, o_byp2;
    logic          o_empty, o_full;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    wb_req_t sb[$];

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_alu_valid (i_alu_valid),
        .i_alu_addr  (i_alu_addr),
        .i_alu_data  (i_alu_data),
        .o_alu_ready (o_alu_ready),
        .i_mem_valid (i_mem_valid),
        .i_mem_addr  (i_mem_addr),
        .i_mem_data  (i_mem_data),
        .o_mem_ready (o_mem_ready),
        .o_rf_we     (o_rf_we),
        .o_rf_waddr  (o_rf_waddr),
        .o_rf_wdata  (o_rf_wdata),
        .i_ra1       (i_ra1),
        .i_ra2       (i_ra2),
        .o_hit1      (o_hit1),
        .o_hit2      (o_hit2),
        .o_byp1      (o_byp1),
        .o_byp2      (o_byp2),
        .o_empty     (o_empty),
        .o_full      (o_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: check handshake state mid-cycle, then the write port
    task automatic step();
        bit mrdy, ardy, mfire, afire, push, pop, exp_we;
        wb_req_t req, got;
        @(negedge clk);
        mrdy = (mcount != DEPTH);
        ardy = mrdy && !i_mem_valid;
        chk("empty", o_empty, mcount == 0);
        chk("full", o_full, mcount == DEPTH);
        chk("mem_ready", o_mem_ready, mrdy);
        chk("alu_ready", o_alu_ready, ardy);
        mfire = i_mem_valid && mrdy;
        afire = i_alu_valid && ardy;
        req.addr = mfire ? i_mem_addr : i_alu_addr;
        req.data = mfire ? i_mem_data : i_alu_data;
        push = (mfire || afire) && (req.addr != 0) && !rst;
        pop = (mcount > 0);
        @(posedge clk);
        #1;
        exp_we = pop && !rst;
        chk("rf_we", o_rf_we, exp_we);
        if (o_rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                got = sb.pop_front();
                chk("rf_waddr", o_rf_waddr, got.addr);
                chk("rf_wdata", o_rf_wdata, got.data);
            end
        end
        if (rst) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (push) sb.push_back(req);
            mcount = mcount + int'(push) - int'(pop);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        step();
        chk("rst_waddr", o_rf_waddr, 0);
        chk("rst_wdata", o_rf_wdata, 0);
        rst = 1'b0;
        step();

        // single ALU write, 2-cycle latency
        i_alu_valid = 1; i_alu_addr = 3; i_alu_data = 32'hA5A5A5A5;
        step();
        i_alu_valid = 0;
        step();
        step();

        // load wins over ALU, ALU follows next cycle
        i_alu_valid = 1; i_alu_addr = 4; i_alu_data = 32'h44;
        i_mem_valid = 1; i_mem_addr = 5; i_mem_data = 32'h55;
        step();
        i_mem_valid = 0;
        step();
        i_alu_valid = 0;
        repeat (3) step();

        // back-to-back loads never fill the queue
        for (int i = 0; i < 6; i++) begin
            i_mem_valid = 1;
            i_mem_addr = AW'(8 + i);
            i_mem_data = $urandom;
            step();
        end
        i_mem_valid = 0;
        repeat (3) step();

        // same address twice: youngest bypass, two writes
        i_alu_valid = 1; i_alu_addr = 7; i_alu_data = 1;
        step();
        i_alu_data = 2;
        step();
        i_alu_valid = 0;
        i_ra1 = 7; i_ra2 = 0;
        #1;
        chk("hit1_young", o_hit1, 1);
        chk("byp1_young", o_byp1, 2);
        chk("hit2_zero", o_hit2, 0);
        chk("byp2_zero", o_byp2, 0);
        i_ra2 = 30;
        #1;
        chk("hit2_none", o_hit2, 0);
        chk("byp2_none", o_byp2, 0);
        step();
        chk("hit1_port", o_hit1, 1);
        chk("byp1_port", o_byp1, 2);
        step();
        chk("hit1_gone", o_hit1, 0);
        chk("byp1_gone", o_byp1, 0);

        // write-port entry and FIFO entry with distinct addresses
        i_alu_valid = 1; i_alu_addr = 9; i_alu_data = 32'h99;
        step();
        i_alu_addr = 10; i_alu_data = 32'hAA;
        step();
        i_alu_valid = 0;
        i_ra1 = 9; i_ra2 = 10;
        #1;
        chk("hit1_old", o_hit1, 1);
        chk("byp1_old", o_byp1, 32'h99);
        chk("hit2_new", o_hit2, 1);
        chk("byp2_new", o_byp2, 32'hAA);
        i_ra1 = 0; i_ra2 = 0;
        step();
        step();

        // x0 write: accepted, dropped
        i_alu_valid = 1; i_alu_addr = 0; i_alu_data = 32'hDEAD;
        step();
        i_alu_valid = 0;
        step();
        step();

        // reset with work in flight discards it
        i_mem_valid = 1; i_mem_addr = 12; i_mem_data = 32'hC;
        step();
        i_mem_addr = 13; i_mem_data = 32'hD;
        step();
        rst = 1; i_mem_addr = 14; i_mem_data = 32'hE;
        step();
        rst = 0; i_mem_valid = 0;
        repeat (3) step();

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
